delay_window_scheduler: RTL and testbench

// - Multi-slot scheduler for "a ##[MIN_DLY:MAX_DLY] b" delay checking. Generalises the single-trigger 3-cycle delay FSM.
// - Each trigger on a claims a private delay-tracking slot, so overlapping triggers are all tracked.
// - Each slot counts cycles until b arrives in the window (match) or the window expires (miss).
// - Sits beside the delay-operator checkers and feeds cover/assert logic with match, miss and overflow events.

---
 rtl/delay_window_if.sv | 28 ++
 rtl/delay_window_scheduler.sv | 143 ++++++++++++++
 tb/tb_delay_window_scheduler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_window_if.sv
// Handshake bundle for delay_window_scheduler: trigger/response inputs plus
// the match/miss/overflow event outputs and occupancy status.
interface delay_window_if #(
  parameter int NUM_SLOTS = 4
);
  localparam int SW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic             a;
  logic             b;
  logic             match;
  logic [SW-1:0]    match_slot;
  logic             miss;
  logic [SW-1:0]    miss_slot;
  logic             overflow;
  logic [CNT_W-1:0] active_cnt;
  logic             busy;

  modport master (
    output a, b,
    input  match, match_slot, miss, miss_slot, overflow, active_cnt, busy
  );

  modport slave (
    input  a, b,
    output match, match_slot, miss, miss_slot, overflow, active_cnt, busy
  );
endinterface

// File: rtl/delay_window_scheduler.sv
// Multi-slot tracker for "a ##[MIN_DLY:MAX_DLY] b": every trigger owns a slot
// that ages until b lands in its window (match) or the window closes (miss).
module delay_window_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int MIN_DLY   = 3,
  parameter int MAX_DLY   = 3
) (
  input logic           clk,
  input logic           rst,
  delay_window_if.slave dw
);
  localparam int AGE_W = $clog2(MAX_DLY + 1);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int SW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [AGE_W-1:0] MIN_AGE = AGE_W'(MIN_DLY);
  localparam logic [AGE_W-1:0] MAX_AGE = AGE_W'(MAX_DLY);

  logic [NUM_SLOTS-1:0] valid_r;
  logic [NUM_SLOTS-1:0] valid_s;
  logic [AGE_W-1:0]     age_r [NUM_SLOTS];
  logic [AGE_W-1:0]     age_s [NUM_SLOTS];

  logic             match_r;
  logic [SW-1:0]    match_slot_r;
  logic             miss_r;
  logic [SW-1:0]    miss_slot_r;
  logic             overflow_r;
  logic [CNT_W-1:0] active_cnt_r;
  logic             busy_r;

  logic             win_hit_s;
  logic [SW-1:0]    win_idx_s;
  logic [AGE_W-1:0] win_age_s;
  logic             exp_hit_s;
  logic [SW-1:0]    exp_idx_s;
  logic             free_hit_s;
  logic [SW-1:0]    free_idx_s;
  logic             do_match_s;
  logic             do_miss_s;
  logic             retire_s;
  logic [SW-1:0]    ret_idx_s;
  logic             alloc_s;
  logic             overflow_s;
  logic [CNT_W-1:0] cnt_s;
  logic [NUM_SLOTS-1:0] in_win_s;

  // Slot search (oldest in-window, expiring, lowest free) and next slot state
  always_comb begin
    win_hit_s  = 1'b0;
    win_idx_s  = '0;
    win_age_s  = '0;
    exp_hit_s  = 1'b0;
    exp_idx_s  = '0;
    free_hit_s = 1'b0;
    free_idx_s = '0;
    in_win_s   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      in_win_s[i] = valid_r[i] && (age_r[i] >= MIN_AGE) && (age_r[i] <= MAX_AGE)
                    && (!win_hit_s || (age_r[i] > win_age_s));
      win_idx_s   = in_win_s[i] ? SW'(i) : win_idx_s;
      win_age_s   = in_win_s[i] ? age_r[i] : win_age_s;
      win_hit_s   = win_hit_s | in_win_s[i];
      exp_idx_s   = (valid_r[i] && (age_r[i] == MAX_AGE)) ? SW'(i) : exp_idx_s;
      exp_hit_s   = exp_hit_s | (valid_r[i] && (age_r[i] == MAX_AGE));
    end
    // Descending scan so the lowest free index wins
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      free_idx_s = !valid_r[i] ? SW'(i) : free_idx_s;
      free_hit_s = free_hit_s | !valid_r[i];
    end

    do_match_s = dw.b && win_hit_s;
    do_miss_s  = !dw.b && exp_hit_s;
    retire_s   = do_match_s || do_miss_s;
    ret_idx_s  = do_match_s ? win_idx_s : exp_idx_s;
    alloc_s    = dw.a && free_hit_s;
    overflow_s = dw.a && !free_hit_s;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      valid_s[i] = valid_r[i];
      age_s[i]   = age_r[i];
      if (retire_s && (ret_idx_s == SW'(i))) begin
        valid_s[i] = 1'b0;
        age_s[i]   = '0;
      end else if (valid_r[i]) begin
        age_s[i] = age_r[i] + AGE_W'(1);
      end else if (alloc_s && (free_idx_s == SW'(i))) begin
        valid_s[i] = 1'b1;
        age_s[i]   = AGE_W'(1);
      end else begin
        valid_s[i] = 1'b0;
        age_s[i]   = '0;
      end
    end

    cnt_s = active_cnt_r + CNT_W'(alloc_s) - CNT_W'(retire_s);
  end

  // Slot and registered-output state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        age_r[i] <= '0;
      end
      match_r      <= 1'b0;
      match_slot_r <= '0;
      miss_r       <= 1'b0;
      miss_slot_r  <= '0;
      overflow_r   <= 1'b0;
      active_cnt_r <= '0;
      busy_r       <= 1'b0;
    end else begin
      valid_r      <= valid_s;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        age_r[i] <= age_s[i];
      end
      match_r      <= do_match_s;
      miss_r       <= do_miss_s;
      overflow_r   <= overflow_s;
      active_cnt_r <= cnt_s;
      busy_r       <= (cnt_s != '0);
      if (do_match_s) begin
        match_slot_r <= win_idx_s;
      end else begin
        match_slot_r <= match_slot_r;
      end
      if (do_miss_s) begin
        miss_slot_r <= exp_idx_s;
      end else begin
        miss_slot_r <= miss_slot_r;
      end
    end
  end

  assign dw.match      = match_r;
  assign dw.match_slot = match_slot_r;
  assign dw.miss       = miss_r;
  assign dw.miss_slot  = miss_slot_r;
  assign dw.overflow   = overflow_r;
  assign dw.active_cnt = active_cnt_r;
  assign dw.busy       = busy_r;
endmodule

// File: tb/tb_delay_window_scheduler.sv
// Two scheduler configurations (3..3 and 2..5) driven with the same stimulus;
// a timestamp-based reference model feeds per-instance scoreboard queues.
module tb_delay_window_scheduler;
  localparam int NS = 4;

  typedef struct {
    logic match;
    int   match_slot;
    logic miss;
    int   miss_slot;
    logic ovf;
    int   cnt;
  } exp_t;

  logic clk;
  logic rst;
  logic a_v;
  logic b_v;
  bit   mon_en;

  exp_t q0[$];
  exp_t q1[$];
  int   checks;
  int   errors;

  int min_d [2];
  int max_d [2];
  int trig  [2][NS];
  bit vld   [2][NS];
  int edge_n[2];
  int hold_m[2];
  int hold_x[2];

  logic [1:0] dir_tab [$];

  delay_window_if #(.NUM_SLOTS(NS)) if0 ();
  delay_window_if #(.NUM_SLOTS(NS)) if1 ();

  assign if0.a = a_v;
  assign if0.b = b_v;
  assign if1.a = a_v;
  assign if1.b = b_v;

  delay_window_scheduler #(.NUM_SLOTS(NS), .MIN_DLY(3), .MAX_DLY(3)) dut0 (
    .clk(clk), .rst(rst), .dw(if0.slave)
  );
  delay_window_scheduler #(.NUM_SLOTS(NS), .MIN_DLY(2), .MAX_DLY(5)) dut1 (
    .clk(clk), .rst(rst), .dw(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      edge_n[c] = 0;
      hold_m[c] = 0;
      hold_x[c] = 0;
      for (int s = 0; s < NS; s++) begin
        vld[c][s]  = 1'b0;
        trig[c][s] = 0;
      end
    end
  endtask

  // A slot's age at an edge is simply the number of edges since its trigger.
  task automatic model_step(input int c, input bit a_i, input bit b_i, output exp_t e);
    int win;
    int wage;
    int exp_s;
    int free;
    int age;
    win   = -1;
    wage  = -1;
    exp_s = -1;
    free  = -1;
    e = '{match: 1'b0, match_slot: 0, miss: 1'b0, miss_slot: 0, ovf: 1'b0, cnt: 0};
    for (int s = 0; s < NS; s++) begin
      if (vld[c][s]) begin
        age = edge_n[c] - trig[c][s];
        if (age >= min_d[c] && age <= max_d[c] && age > wage) begin
          win  = s;
          wage = age;
        end
        if (age == max_d[c]) exp_s = s;
      end else if (free < 0) begin
        free = s;
      end
    end
    if (b_i && win >= 0) begin
      vld[c][win] = 1'b0;
      e.match     = 1'b1;
      hold_m[c]   = win;
    end else if (!b_i && exp_s >= 0) begin
      vld[c][exp_s] = 1'b0;
      e.miss        = 1'b1;
      hold_x[c]     = exp_s;
    end
    if (a_i) begin
      if (free >= 0) begin
        vld[c][free]  = 1'b1;
        trig[c][free] = edge_n[c];
      end else begin
        e.ovf = 1'b1;
      end
    end
    e.match_slot = hold_m[c];
    e.miss_slot  = hold_x[c];
    for (int s = 0; s < NS; s++) e.cnt += int'(vld[c][s]);
    edge_n[c]++;
  endtask

  task automatic push_expect(input bit ai, input bit bi);
    exp_t e;
    model_step(0, ai, bi, e);
    q0.push_back(e);
    model_step(1, ai, bi, e);
    q1.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic step(input bit ai, input bit bi);
    @(negedge clk);
    #1;
    a_v = ai;
    b_v = bi;
    push_expect(ai, bi);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_match0"}, int'(if0.match), 0);
    chk({tag, "_miss0"}, int'(if0.miss), 0);
    chk({tag, "_ovf0"}, int'(if0.overflow), 0);
    chk({tag, "_cnt0"}, int'(if0.active_cnt), 0);
    chk({tag, "_busy0"}, int'(if0.busy), 0);
    chk({tag, "_mslot0"}, int'(if0.match_slot) + int'(if0.miss_slot), 0);
    chk({tag, "_match1"}, int'(if1.match), 0);
    chk({tag, "_cnt1"}, int'(if1.active_cnt), 0);
    chk({tag, "_mslot1"}, int'(if1.match_slot) + int'(if1.miss_slot), 0);
  endtask

  // Mid-operation reset: outputs must clear before the next clock edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    a_v = 1'b0;
    b_v = 1'b0;
    rst = 1'b1;
    #1;
    check_zero("midreset");
    #2;
    rst = 1'b0;
    model_reset();
    push_expect(1'b0, 1'b0);
  endtask

  task automatic compare(input int c, input exp_t e, input logic m, input int ms,
                         input logic x, input int xs, input logic o, input int cnt,
                         input logic busy);
    string p;
    p = (c == 0) ? "d0" : "d1";
    chk({p, "_match"}, int'(m), int'(e.match));
    chk({p, "_match_slot"}, ms, e.match_slot);
    chk({p, "_miss"}, int'(x), int'(e.miss));
    chk({p, "_miss_slot"}, xs, e.miss_slot);
    chk({p, "_overflow"}, int'(o), int'(e.ovf));
    chk({p, "_active_cnt"}, cnt, e.cnt);
    chk({p, "_busy"}, int'(busy), int'(e.cnt != 0));
  endtask

  // Scoreboard monitor: one expectation per instance per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got %0d/%0d entries expected >0", q0.size(), q1.size());
        end else begin
          e = q0.pop_front();
          compare(0, e, if0.match, int'(if0.match_slot), if0.miss, int'(if0.miss_slot),
                  if0.overflow, int'(if0.active_cnt), if0.busy);
          e = q1.pop_front();
          compare(1, e, if1.match, int'(if1.match_slot), if1.miss, int'(if1.miss_slot),
                  if1.overflow, int'(if1.active_cnt), if1.busy);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    min_d  = '{3, 2};
    max_d  = '{3, 5};
    a_v    = 1'b0;
    b_v    = 1'b0;
    model_reset();
    rst = 1'b1;
    #8;
    check_zero("reset");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Directed sequences: {a,b} per edge
    dir_tab = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00,
                2'b00, 2'b00, 2'b00,
                2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b00, 2'b00, 2'b00,
                2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b00, 2'b00, 2'b00};
    foreach (dir_tab[i]) step(dir_tab[i][1], dir_tab[i][0]);

    // Trigger, reset between edges 1 and 2, late b must not produce any event
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 1) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 45);
      end
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("sb_drain", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
